z80_int_timer: RTL
==================

# z80_int_timer

I/O-mapped 16-bit interval timer that raises a Z80 maskable interrupt and responds to the CPU interrupt-acknowledge cycle with a programmable vector. It is a responder on the fz80 I/O bus and on the interrupt request/acknowledge protocol, which the CPU initiates. It sits beside simple_sio on the `cpu_clk` domain. It is decoded at I/O 0x88–0x8B, so its `ce` is asserted when `cpu_addr[7:2]` equals 6'b100010. Its `intreq` drives `fz80.intreq`, and `fz80.intack_out` drives its `intack`.

## Interface
Parameters:
- PRESCALE, 16: `cpu_clk` cycles per counter tick; legal range 1..256.

Ports:
- cpu_clk  in  1  system clock for the block.
- n_RST  in  1  reset, asynchronous, active-low.
- ce  in  1  chip select from the I/O address decoder.
- rd  in  1  I/O read strobe (`iorq & rd`).
- wr  in  1  I/O write strobe (`iorq & wr`).
- addr  in  2  register select (`cpu_addr[1:0]`).
- data_in  in  8  CPU write data.
- data_out  out  8  read or vector data; 8'h00 when not driving.
- data_oe  out  1  high when `data_out` is valid; used by the top-level read mux.
- intreq  out  1  interrupt request to the CPU.
- intack  in  1  interrupt acknowledge from the CPU.

## Operation
Register map:
- 0 CTRL
  - Write: bit0 EN, bit1 IE, bit2 ONESHOT, bit7 CLR. CLR is write-1-to-clear for PEND.
  - Read: {PEND, 4'b0, ONESHOT, IE, EN}.
- 1 RELOAD_LO / CNT_LO
  - Write sets reload[7:0].
  - Read returns live cnt[7:0] and snapshots cnt[15:8] into a hi-latch on the same cycle.
- 2 RELOAD_HI / CNT_HI
  - Write sets reload[15:8].
  - Read returns the hi-latch, not the live counter.
- 3 VECTOR
  - Read/write of the 8-bit vector. Bit0 is forced to 0 on write, for mode-2 alignment.

Write timing:
- A write is taken on the first cycle in which `ce & wr` is high.
- An edge detector ensures each strobe pulse causes exactly one write.

Counting:
- An EN 0→1 transition caused by a CTRL write loads cnt ← reload and clears the prescaler.
- While EN=1, the prescaler counts 0..PRESCALE-1. At wrap it emits a one-cycle tick.
- Each tick decrements cnt modulo 2^16. Reload 0 therefore gives a period of 65536 ticks.
- When cnt is 1 at a tick (terminal count):
  - PEND is set.
  - Periodic mode (ONESHOT=0): cnt ← reload on the same cycle.
  - One-shot mode (ONESHOT=1): cnt ← 0 and EN ← 0.
- Writing EN=0 freezes cnt and the prescaler. Re-enabling reloads the counter.
- Writing RELOAD while running does not affect cnt until the next reload.

Interrupt:
- `intreq = PEND & IE`.
- Acknowledge state machine states: IDLE, ACK.
  - IDLE→ACK when `intack & intreq`.
  - In ACK: `data_out = VECTOR` and `data_oe = 1`.
  - ACK→IDLE when `intack` falls. PEND is cleared on that cycle.
- `intack` arriving while `intreq = 0` is ignored: no drive, no state change.

Reads:
- When `ce & rd`, `data_out` is driven combinationally and `data_oe = 1`.
- When neither a read nor ACK is active, `data_out = 0` and `data_oe = 0`.

## Timing
- Reset values:
  - Registers: cnt, reload, hi-latch, VECTOR, prescaler, EN, IE, ONESHOT and PEND are all 0.
  - Outputs: `intreq` = 0, `data_out` = 0, `data_oe` = 0.
  - State machine: IDLE.
- Reset asserted mid-count or mid-ACK returns the block to the reset state immediately.
- Interrupt period is `reload × PRESCALE` cycles (reload=0 → 65536 × PRESCALE).
- PEND and `intreq` go high on the cycle after the terminal tick, because PEND is registered.
- Simultaneous events:
  - Terminal tick and PEND clear (CLR write or ACK exit) on the same cycle: set wins, so PEND stays 1.
  - EN 0→1 write and a tick on the same cycle: the load wins and the tick is discarded.
  - CTRL write with EN=1 while already running: no reload. Only IE, ONESHOT and CLR take effect.

## Structure
- Package `z80_int_timer_pkg` holds:
  - register address constants: REG_CTRL, REG_CNT_LO, REG_CNT_HI, REG_VECTOR;
  - CTRL bit positions: EN, IE, ONESHOT, CLR/PEND;
  - the acknowledge state enum {IDLE, ACK}.
- Sub-module `tick_prescaler` (parameter PRESCALE; inputs en, clr; output tick) is a separate unit.
- Counter, registers and acknowledge state machine live in the top module. Estimated size about 200 lines.

## Test plan
- Reset: after reset, all register reads return 0x00, `intreq` = 0 and `data_oe` = 0.
- Periodic: PRESCALE=16, reload=0x0003, CTRL=0x03 → `intreq` rises 49 cycles after the write (the 48-cycle period plus one registered cycle). After a CLR write, the next rise comes 48 cycles after the previous one.
- One-shot: CTRL=0x07, reload=0x0002 → PEND is set once, EN reads 0, cnt reads 0x0000, and no second interrupt occurs.
- Acknowledge: VECTOR=0x41 is written and reads back 0x40. With `intreq` high, pulse `intack` → `data_out` = 0x40 while `intack` is high, and PEND clears when `intack` falls.
- Race: force a terminal tick on the same cycle as a CLR write → PEND remains 1.
- Snapshot: counter at 0x0100, read LO (returns 0x00). Then let ticks occur and read HI → returns 0x01 (the latched value), not the live counter.

Source files
------------

// File: rtl/z80_int_timer_pkg.sv
// z80_int_timer shared definitions.
// Register map, CTRL bit positions and acknowledge states.
package z80_int_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_CNT_LO = 2'd1;
    localparam logic [1:0] REG_CNT_HI = 2'd2;
    localparam logic [1:0] REG_VECTOR = 2'd3;

    localparam int BIT_EN      = 0;
    localparam int BIT_IE      = 1;
    localparam int BIT_ONESHOT = 2;
    localparam int BIT_CLR     = 7;
    localparam int BIT_PEND    = 7;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } ack_state_t;

endpackage

// File: rtl/z80_int_timer_tick.sv
// Prescaler for z80_int_timer.
// Divides cpu_clk down to a one-cycle tick every PRESCALE cycles.
module tick_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic cpu_clk,
    input  logic n_RST,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] pcnt_q;
    logic [W-1:0] pcnt_d;

    // Next count; clr discards any tick on the same cycle.
    always_comb begin
        pcnt_d = pcnt_q;
        tick   = 1'b0;
        if (clr) begin
            pcnt_d = '0;
        end else if (en) begin
            if (pcnt_q == LAST) begin
                pcnt_d = '0;
                tick   = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    // Prescaler count register.
    always_ff @(posedge cpu_clk or negedge n_RST) begin
        if (!n_RST) pcnt_q <= '0;
        else        pcnt_q <= pcnt_d;
    end

endmodule

// File: rtl/z80_int_timer.sv
// I/O-mapped 16-bit interval timer with Z80 mode-2 vectored interrupt.
// Counter, registers and acknowledge FSM; prescaler is a sub-unit.
module z80_int_timer
    import z80_int_timer_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic       cpu_clk,
    input  logic       n_RST,
    input  logic       ce,
    input  logic       rd,
    input  logic       wr,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       intreq,
    input  logic       intack
);

    logic        wr_prev_q, wr_prev_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        os_q, os_d;
    logic        pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] reload_q, reload_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  vec_q, vec_d;
    ack_state_t  state_q;

    logic wr_pulse;
    logic wr_ctrl;
    logic load;
    logic tick;
    logic ack_exit;

    assign wr_pulse = ce & wr & ~wr_prev_q;
    assign wr_ctrl  = wr_pulse & (addr == REG_CTRL);
    assign load     = wr_ctrl & data_in[BIT_EN] & ~en_q;
    assign ack_exit = (state_q == ACK) & ~intack;
    assign intreq   = pend_q & ie_q;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_presc (
        .cpu_clk(cpu_clk),
        .n_RST  (n_RST),
        .en     (en_q),
        .clr    (load),
        .tick   (tick)
    );

    // Register writes, counting and PEND set/clear (set wins).
    always_comb begin
        wr_prev_d = ce & wr;
        en_d      = en_q;
        ie_d      = ie_q;
        os_d      = os_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        hi_d      = hi_q;
        vec_d     = vec_q;

        if (wr_ctrl) begin
            en_d = data_in[BIT_EN];
            ie_d = data_in[BIT_IE];
            os_d = data_in[BIT_ONESHOT];
            if (data_in[BIT_CLR]) pend_d = 1'b0;
        end
        if (wr_pulse && addr == REG_CNT_LO) reload_d[7:0]  = data_in;
        if (wr_pulse && addr == REG_CNT_HI) reload_d[15:8] = data_in;
        if (wr_pulse && addr == REG_VECTOR) vec_d = {data_in[7:1], 1'b0};

        if (ack_exit) pend_d = 1'b0;

        if (load) begin
            cnt_d = reload_q;
        end else if (tick) begin
            if (cnt_q == 16'd1) begin
                pend_d = 1'b1;
                if (os_q) begin
                    cnt_d = 16'd0;
                    en_d  = 1'b0;
                end else begin
                    cnt_d = reload_q;
                end
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end

        if (ce && rd && addr == REG_CNT_LO) hi_d = cnt_q[15:8];
    end

    // Read / vector output mux; ACK drive has priority.
    always_comb begin
        data_out = 8'h00;
        data_oe  = 1'b0;
        if (state_q == ACK) begin
            data_out = vec_q;
            data_oe  = 1'b1;
        end else if (ce && rd) begin
            data_oe = 1'b1;
            unique case (addr)
                REG_CTRL: begin
                    data_out           = 8'h00;
                    data_out[BIT_PEND] = pend_q;
                    data_out[BIT_EN]   = en_q;
                    data_out[BIT_IE]   = ie_q;
                    data_out[BIT_ONESHOT] = os_q;
                end
                REG_CNT_LO: data_out = cnt_q[7:0];
                REG_CNT_HI: data_out = hi_q;
                REG_VECTOR: data_out = vec_q;
            endcase
        end
    end

    // Timer state registers.
    always_ff @(posedge cpu_clk or negedge n_RST) begin
        if (!n_RST) begin
            wr_prev_q <= 1'b0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            os_q      <= 1'b0;
            pend_q    <= 1'b0;
            cnt_q     <= 16'h0000;
            reload_q  <= 16'h0000;
            hi_q      <= 8'h00;
            vec_q     <= 8'h00;
        end else begin
            wr_prev_q <= wr_prev_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            os_q      <= os_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            reload_q  <= reload_d;
            hi_q      <= hi_d;
            vec_q     <= vec_d;
        end
    end

    // Interrupt acknowledge state machine.
    always_ff @(posedge cpu_clk or negedge n_RST) begin
        if (!n_RST) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (intack && intreq) state_q <= ACK;
                ACK:  if (!intack)          state_q <= IDLE;
            endcase
        end
    end

endmodule
